// File: rtl/cdc_handshake_tx_if.sv
// Signal bundle between the local producer, the CDC sender and the destination domain.
// Carries timeout_err only when CDC_TX_TIMEOUT_EN is defined.
interface cdc_handshake_tx_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             tx_req;
    logic [WIDTH-1:0] tx_data;
    logic             tx_ack;
    logic             busy;
    logic             done;
`ifdef CDC_TX_TIMEOUT_EN
    logic             timeout_err;

    // master is the sender block; slave is the producer/destination environment
    modport master (
        input  in_valid, in_data, tx_ack,
        output in_ready, tx_req, tx_data, busy, done, timeout_err
    );
    modport slave (
        output in_valid, in_data, tx_ack,
        input  in_ready, tx_req, tx_data, busy, done, timeout_err
    );
`else
    modport master (
        input  in_valid, in_data, tx_ack,
        output in_ready, tx_req, tx_data, busy, done
    );
    modport slave (
        output in_valid, in_data, tx_ack,
        input  in_ready, tx_req, tx_data, busy, done
    );
`endif
endinterface

// File: rtl/cdc_handshake_tx.sv
// Transmit end of a 4-phase req/ack CDC handshake; tx_ack is resynchronised locally.
// Optional wait-timeout flag is built when CDC_TX_TIMEOUT_EN is defined.
module cdc_handshake_tx #(
    parameter int WIDTH          = 8,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                rst,
    cdc_handshake_tx_if.master  bus
);
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    logic [1:0]             r_state;
    logic [SYNC_STAGES-1:0] r_ack_sync;
    logic                   r_tx_req;
    logic [WIDTH-1:0]       r_tx_data;
    logic                   r_busy;
    logic                   r_done;

    logic w_ack_sync;
    logic w_in_ready;
    logic w_accept;

    assign w_ack_sync = r_ack_sync[SYNC_STAGES-1];
    // Gating on r_done keeps a new accept from landing in the done cycle.
    assign w_in_ready = (r_state == ST_IDLE) && !w_ack_sync && !r_done;
    assign w_accept   = bus.in_valid && w_in_ready;

    // NOTE: non-blocking assignments make every stage sample the previous stage's old value,
    // so a tx_ack change takes exactly SYNC_STAGES edges to reach w_ack_sync.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ack_sync <= '0;
        end else begin
            r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], bus.tx_ack};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_tx_req  <= 1'b0;
            r_tx_data <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_tx_data <= bus.in_data;
                        r_tx_req  <= 1'b1;
                        r_busy    <= 1'b1;
                        r_state   <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (w_ack_sync) begin
                        r_tx_req <= 1'b0;
                        r_state  <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (!w_ack_sync) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready = w_in_ready;
    assign bus.tx_req   = r_tx_req;
    assign bus.tx_data  = r_tx_data;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;

`ifdef CDC_TX_TIMEOUT_EN
    localparam logic [16:0] TIMEOUT_LIMIT = 17'(TIMEOUT_CYCLES);

    logic [15:0] r_wait_cnt;
    logic        r_timeout_err;
    logic        w_enter_wait;
    logic [16:0] w_cnt_inc;

    assign w_enter_wait = w_accept || ((r_state == ST_REQ) && w_ack_sync);
    assign w_cnt_inc    = {1'b0, r_wait_cnt} + 17'd1;

    // The flag is sticky and only observes the wait; the FSM is never aborted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait_cnt    <= '0;
            r_timeout_err <= 1'b0;
        end else if (w_enter_wait) begin
            r_wait_cnt <= '0;
        end else if ((r_state == ST_REQ) || (r_state == ST_RELEASE)) begin
            if (r_wait_cnt != 16'hFFFF) begin
                r_wait_cnt <= w_cnt_inc[15:0];
            end
            if (w_cnt_inc >= TIMEOUT_LIMIT) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign bus.timeout_err = r_timeout_err;
`endif
endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Directed self-checking bench for cdc_handshake_tx (SYNC_STAGES=2, TIMEOUT_CYCLES=16).
// Define CDC_TX_TIMEOUT_EN to also exercise the timeout flag.
module tb_cdc_handshake_tx;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cdc_handshake_tx_if #(.WIDTH(8)) bus ();

    cdc_handshake_tx #(
        .WIDTH         (8),
        .SYNC_STAGES   (2),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    int         checks   = 0;
    int         failures = 0;
    int         done_cnt = 0;
    int         acc_cnt  = 0;
    int         bad_cnt  = 0;
    int         n;
    int         start;
    logic       auto_ack = 1'b0;
    logic [7:0] exp_hold = 8'h00;
    logic [7:0] seq[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: record an accept before the edge, monitor invariants after it,
    // and let the destination model echo tx_req onto tx_ack when enabled.
    task automatic cyc();
        if (bus.in_valid && bus.in_ready && !rst) begin
            exp_hold = bus.in_data;
            acc_cnt++;
            seq.push_back(bus.in_data);
        end
        @(posedge clk);
        #1;
        if (bus.done) done_cnt++;
        if (bus.tx_req && (bus.tx_data !== exp_hold)) bad_cnt++;
        if (bus.in_ready && (bus.busy || bus.tx_req || bus.done)) bad_cnt++;
        if (auto_ack) bus.tx_ack = bus.tx_req;
    endtask

    initial begin
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.tx_ack   = 1'b0;
        repeat (3) cyc();
        rst = 1'b0;

        // reset release with tx_ack low
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_tx_req",   32'(bus.tx_req),   32'd0);
        check("rst_tx_data",  32'(bus.tx_data),  32'h00);
        check("rst_busy",     32'(bus.busy),     32'd0);
        check("rst_done",     32'(bus.done),     32'd0);

        // single transfer of A5 with an echoing destination
        bus.in_data  = 8'hA5;
        bus.in_valid = 1'b1;
        auto_ack     = 1'b1;
        cyc();
        bus.in_valid = 1'b0;
        check("a5_req_set",   32'(bus.tx_req),   32'd1);
        check("a5_data",      32'(bus.tx_data),  32'hA5);
        check("a5_busy",      32'(bus.busy),     32'd1);
        check("a5_not_ready", 32'(bus.in_ready), 32'd0);
        cyc();
        cyc();
        check("a5_req_hold",  32'(bus.tx_req),   32'd1);
        check("a5_data_hold", 32'(bus.tx_data),  32'hA5);
        cyc();
        check("a5_req_drop",  32'(bus.tx_req),   32'd0);
        check("a5_busy_rel",  32'(bus.busy),     32'd1);
        check("a5_data_rel",  32'(bus.tx_data),  32'hA5);
        cyc();
        cyc();
        check("a5_no_early_done", 32'(bus.done), 32'd0);
        cyc();
        check("a5_done",       32'(bus.done),     32'd1);
        check("a5_busy_clr",   32'(bus.busy),     32'd0);
        check("a5_ready_in_done", 32'(bus.in_ready), 32'd0);
        cyc();
        check("a5_done_pulse", 32'(bus.done),     32'd0);
        check("a5_ready_back", 32'(bus.in_ready), 32'd1);
        check("a5_done_count", 32'(done_cnt),     32'd1);

        // back-to-back words with in_valid held high
        done_cnt = 0;
        acc_cnt  = 0;
        seq.delete();
        for (int w = 1; w <= 3; w++) begin
            bus.in_data  = 8'(w);
            bus.in_valid = 1'b1;
            start = acc_cnt;
            n = 0;
            while (acc_cnt == start && n < 100) begin
                cyc();
                n++;
            end
            check("b2b_accept_data", 32'(bus.tx_data), 32'(w));
        end
        bus.in_valid = 1'b0;
        n = 0;
        while (done_cnt < 3 && n < 100) begin
            cyc();
            n++;
        end
        cyc();
        check("b2b_accepts", 32'(acc_cnt),    32'd3);
        check("b2b_dones",   32'(done_cnt),   32'd3);
        check("b2b_seq_len", 32'(seq.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            check("b2b_seq_word", 32'(seq[i]), 32'(i + 1));
        end

        // stale ack high across reset release
        auto_ack   = 1'b0;
        bus.tx_ack = 1'b1;
        rst        = 1'b1;
        repeat (2) cyc();
        rst = 1'b0;
        cyc();
        cyc();
        check("stale_ready_low", 32'(bus.in_ready), 32'd0);
        bus.in_data  = 8'h77;
        bus.in_valid = 1'b1;
        repeat (3) cyc();
        check("stale_ready_hold", 32'(bus.in_ready), 32'd0);
        check("stale_no_req",     32'(bus.tx_req),   32'd0);
        bus.tx_ack = 1'b0;
        cyc();
        check("stale_ready_1cyc", 32'(bus.in_ready), 32'd0);
        check("stale_no_req_1",   32'(bus.tx_req),   32'd0);
        cyc();
        check("stale_ready_2cyc", 32'(bus.in_ready), 32'd1);
        check("stale_no_req_2",   32'(bus.tx_req),   32'd0);
        cyc();
        check("stale_then_req",  32'(bus.tx_req),  32'd1);
        check("stale_then_data", 32'(bus.tx_data), 32'h77);
        bus.in_valid = 1'b0;
        auto_ack     = 1'b1;
        done_cnt     = 0;
        n = 0;
        while (done_cnt < 1 && n < 50) begin
            cyc();
            n++;
        end
        check("stale_xfer_done", 32'(done_cnt), 32'd1);
        repeat (2) cyc();

        // reset while a request is outstanding
        auto_ack   = 1'b0;
        bus.tx_ack = 1'b0;
        repeat (2) cyc();
        bus.in_data  = 8'h3C;
        bus.in_valid = 1'b1;
        cyc();
        bus.in_valid = 1'b0;
        check("mid_req_set",  32'(bus.tx_req),  32'd1);
        check("mid_req_data", 32'(bus.tx_data), 32'h3C);
        cyc();
        done_cnt = 0;
        rst = 1'b1;
        cyc();
        check("mid_rst_req",   32'(bus.tx_req),   32'd0);
        check("mid_rst_data",  32'(bus.tx_data),  32'h00);
        check("mid_rst_busy",  32'(bus.busy),     32'd0);
        check("mid_rst_done",  32'(bus.done),     32'd0);
        check("mid_rst_ready", 32'(bus.in_ready), 32'd1);
        rst = 1'b0;
        repeat (6) cyc();
        check("mid_rst_no_done", 32'(done_cnt),   32'd0);
        check("mid_rst_idle",    32'(bus.tx_req), 32'd0);

`ifdef CDC_TX_TIMEOUT_EN
        // ack withheld past TIMEOUT_CYCLES, then granted
        bus.in_data  = 8'h5A;
        bus.in_valid = 1'b1;
        cyc();
        bus.in_valid = 1'b0;
        check("to_clear_at_entry", 32'(bus.timeout_err), 32'd0);
        repeat (15) cyc();
        check("to_not_yet", 32'(bus.timeout_err), 32'd0);
        cyc();
        check("to_set_16", 32'(bus.timeout_err), 32'd1);
        check("to_req_kept", 32'(bus.tx_req), 32'd1);
        done_cnt   = 0;
        auto_ack   = 1'b1;
        bus.tx_ack = 1'b1;
        n = 0;
        while (done_cnt < 1 && n < 50) begin
            cyc();
            n++;
        end
        check("to_late_done", 32'(done_cnt),        32'd1);
        check("to_sticky",    32'(bus.timeout_err), 32'd1);
`endif

        check("invariants", 32'(bad_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
